// File: rtl/breath_pwm_multi.sv
// Multi-channel LED PWM with a shared triangular breathing ramp; outputs registered, 1 clk after fcnt.
// Optional BREATH_PWM_CYCLE_CNT_EN adds cycle_cnt, counting falling-to-rising ramp reversals.
module breath_pwm_multi #(
  parameter int NCH         = 4,
  parameter int STEP_DIV    = 50,
  parameter int PWM_MAX     = 999,
  parameter int RAMP_FRAMES = 1,
  localparam int DW         = $clog2(PWM_MAX + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [2*NCH-1:0]  mode,
  input  logic [DW*NCH-1:0] duty_fix,
  output logic [NCH-1:0]    pwm_out,
  output logic [DW-1:0]     level,
  output logic              dir,
  output logic              frame_tick
`ifdef BREATH_PWM_CYCLE_CNT_EN
  ,
  output logic [15:0]       cycle_cnt
`endif
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int RW = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(STEP_DIV - 1);
  localparam logic [RW-1:0] R_LAST = RW'(RAMP_FRAMES - 1);
  localparam logic [DW-1:0] L_MAX  = DW'(PWM_MAX);

  logic [PW-1:0]     pcnt;
  logic [DW-1:0]     fcnt;
  logic [RW-1:0]     rcnt;
  logic [2*NCH-1:0]  mode_sh;
  logic [DW*NCH-1:0] duty_sh;
  logic              tick;
  logic              frame_end;
  logic              step;
  logic [DW-1:0]     duty [NCH];
  logic [NCH-1:0]    pwm_nxt;

  assign tick      = (pcnt == P_LAST);
  assign frame_end = tick && (fcnt == L_MAX);
  assign step      = frame_end && (rcnt == R_LAST);

  // Duty comes only from the shadows, so inputs can change freely mid-frame.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      duty[c] = '0;
      case (mode_sh[2*c +: 2])
        2'b00:   duty[c] = '0;
        2'b01:   duty[c] = duty_sh[c*DW +: DW];
        2'b10:   duty[c] = level;
        default: duty[c] = L_MAX - level;
      endcase
      pwm_nxt[c] = (fcnt < duty[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt       <= '0;
      fcnt       <= '0;
      rcnt       <= '0;
      level      <= '0;
      dir        <= 1'b0;
      mode_sh    <= '0;
      duty_sh    <= '0;
      pwm_out    <= '0;
      frame_tick <= 1'b0;
    end else if (!en) begin
      pcnt       <= '0;
      fcnt       <= '0;
      rcnt       <= '0;
      level      <= '0;
      dir        <= 1'b0;
      mode_sh    <= mode;
      duty_sh    <= duty_fix;
      pwm_out    <= '0;
      frame_tick <= 1'b0;
    end else begin
      pcnt       <= tick ? '0 : pcnt + 1'b1;
      frame_tick <= frame_end;
      pwm_out    <= pwm_nxt;
      if (tick)
        fcnt <= (fcnt == L_MAX) ? '0 : fcnt + 1'b1;
      if (frame_end) begin
        rcnt    <= (rcnt == R_LAST) ? '0 : rcnt + 1'b1;
        mode_sh <= mode;
        duty_sh <= duty_fix;
      end
      // Reversal skips the end value so the ramp never dwells at 0 or PWM_MAX.
      if (step) begin
        if (!dir) begin
          if (level == L_MAX) begin
            dir   <= 1'b1;
            level <= L_MAX - 1'b1;
          end else begin
            level <= level + 1'b1;
          end
        end else begin
          if (level == '0) begin
            dir   <= 1'b0;
            level <= DW'(1);
          end else begin
            level <= level - 1'b1;
          end
        end
      end
    end
  end

`ifdef BREATH_PWM_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycle_cnt <= '0;
    else if (!en)
      cycle_cnt <= '0;
    else if (step && dir && (level == '0))
      cycle_cnt <= cycle_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_breath_pwm_multi.sv
// Randomized bench for breath_pwm_multi against an arithmetic model of frames and ramp steps.
module tb_breath_pwm_multi;
  localparam int NCH   = 4;
  localparam int SD    = 2;
  localparam int PM    = 3;
  localparam int RF    = 1;
  localparam int DW    = $clog2(PM + 2);
  localparam int FRAME = SD * (PM + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [2*NCH-1:0]  mode = '0;
  logic [DW*NCH-1:0] duty_fix = '0;
  logic [NCH-1:0]    pwm_out;
  logic [DW-1:0]     level;
  logic              dir;
  logic              frame_tick;
`ifdef BREATH_PWM_CYCLE_CNT_EN
  logic [15:0]       cycle_cnt;
`endif

  breath_pwm_multi #(.NCH(NCH), .STEP_DIV(SD), .PWM_MAX(PM), .RAMP_FRAMES(RF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .duty_fix   (duty_fix),
    .pwm_out    (pwm_out),
    .level      (level),
    .dir        (dir),
    .frame_tick (frame_tick)
`ifdef BREATH_PWM_CYCLE_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: n = enabled clocks since the last clear; everything else is derived from it.
  int             n;
  int             sh_mode [NCH];
  int             sh_duty [NCH];
  logic [NCH-1:0] e_pwm;
  int             e_level;
  int             e_dir;
  int             e_ft;
  int             e_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int lvl_of(input int s);
    int m;
    m = s % (2 * PM);
    return (m <= PM) ? m : 2 * PM - m;
  endfunction

  function automatic int dir_of(input int s);
    int m;
    m = s % (2 * PM);
    return (s > 0 && (m == 0 || m > PM)) ? 1 : 0;
  endfunction

  function automatic int duty_of(input int m, input int d, input int lv);
    case (m)
      0:       return 0;
      1:       return d;
      2:       return lv;
      default: return PM - lv;
    endcase
  endfunction

  task automatic load_shadows();
    for (int c = 0; c < NCH; c++) begin
      sh_mode[c] = int'(mode[2*c +: 2]);
      sh_duty[c] = int'(duty_fix[c*DW +: DW]);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int c = 0; c < NCH; c++) begin
      sh_mode[c] = 0;
      sh_duty[c] = 0;
    end
    e_pwm = '0; e_level = 0; e_dir = 0; e_ft = 0; e_cyc = 0;
  endtask

  task automatic model_step();
    int k, fr, fc, lv, s;
    if (!rst_n) begin
      model_reset();
    end else if (!en) begin
      n = 0;
      load_shadows();
      e_pwm = '0; e_level = 0; e_dir = 0; e_ft = 0; e_cyc = 0;
    end else begin
      k  = n;
      fr = k / FRAME;
      fc = (k / SD) % (PM + 1);
      lv = lvl_of(fr / RF);
      for (int c = 0; c < NCH; c++)
        e_pwm[c] = (fc < duty_of(sh_mode[c], sh_duty[c], lv));
      e_ft = (k % FRAME == FRAME - 1) ? 1 : 0;
      if (e_ft != 0) load_shadows();
      n = k + 1;
      s = (n / FRAME) / RF;
      e_level = lvl_of(s);
      e_dir   = dir_of(s);
      e_cyc   = (s >= 1) ? (((s - 1) / (2 * PM)) % 65536) : 0;
    end
  endtask

  task automatic compare(input string tag);
    check({tag, ".pwm_out"}, 32'(pwm_out), 32'(e_pwm));
    check({tag, ".level"}, 32'(level), e_level);
    check({tag, ".dir"}, 32'(dir), e_dir);
    check({tag, ".frame_tick"}, 32'(frame_tick), e_ft);
`ifdef BREATH_PWM_CYCLE_CNT_EN
    check({tag, ".cycle_cnt"}, 32'(cycle_cnt), e_cyc);
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare(tag);
  endtask

  // Called at posedge+1; asserts reset between edges and expects immediate clearing.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare("async_rst");
    cycle("in_rst");
    cycle("in_rst");
    rst_n = 1'b1;
  endtask

  task automatic set_duty(input int c, input int d);
    duty_fix[c*DW +: DW] = DW'(d);
  endtask

  int en_off;

  initial begin
    model_reset();
    repeat (3) cycle("reset");
    rst_n = 1'b1;
    mode  = 8'b00_01_11_10;
    set_duty(2, 2);
    repeat (2) cycle("idle");
    en = 1'b1;
    // Breathe, inverted breathe and fixed duty side by side over a full breath period.
    repeat (8 * FRAME) cycle("breathe");
    set_duty(2, 0);
    repeat (2 * FRAME) cycle("fix0");
    set_duty(2, 4);
    repeat (2 * FRAME) cycle("fix4");
    set_duty(2, 2);
    repeat (FRAME + 2) cycle("fix2");
    mode[5:4] = 2'b00;
    repeat (2 * FRAME) cycle("midframe");
    en = 1'b0;
    repeat (5) cycle("en_low");
    en = 1'b1;
    repeat (3 * FRAME) cycle("en_back");
    for (int i = 0; i < 4 * FRAME && e_pwm == '0; i++) cycle("wait_hi");
    async_reset();
    repeat (2 * FRAME) cycle("post_rst");

    en_off = 0;
    for (int i = 0; i < 1500; i++) begin
      cycle("rand");
      if (en_off > 0) begin
        en_off--;
        if (en_off == 0) en = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        en     = 1'b0;
        en_off = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 39) == 0) mode = (2*NCH)'($urandom);
      if ($urandom_range(0, 29) == 0)
        for (int c = 0; c < NCH; c++) set_duty(c, $urandom_range(0, 5));
      if (i == 700) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
